mc_ctrl: RTL and testbench

// Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// It drives the datapath's pc write enable, regfile write enable and every mux select.
// It arbitrates one shared single-port memory between instruction fetch and load/store, using a req/ready handshake.
// It traps on an illegal opcode or a memory timeout, and counts retired instructions.

---
 rtl/mc_ctrl_if.sv | 26 ++
 rtl/mc_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Shared single-port memory bus between the sequencer (master) and memory (slave).
//
// Handshake: a transfer completes in the cycle where mem_req and mem_ready are
// both 1. While mem_req=1 and mem_ready=0 the master holds mem_req, mem_we and
// mem_addr_sel stable; it withdraws mem_req only on completion or on timeout.
// mem_ready carries no meaning in cycles where mem_req=0.
interface mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared
// memory port, illegal-opcode and memory-timeout traps, and a retired count.
// o_dbg_state encoding: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 TRAP.
module mc_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic                 br_taken,
   mc_ctrl_if.master            mem,
   output logic                 ir_wr_en,
   output logic                 pc_wr_en,
   output logic                 rf_wr_en,
   output logic                 sel_alu0,
   output logic                 sel_alu1,
   output logic                 sel_ex,
   output logic                 sel_res,
   output logic                 sel_rf_wr,
   output logic                 sel_pc,
   output logic [3:0]           alu_op,
   output logic                 trap,
   output logic [CNT_WIDTH-1:0] instret,
   output logic [2:0]           o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_LUI    = 4'd0,
      C_AUIPC  = 4'd1,
      C_JAL    = 4'd2,
      C_JALR   = 4'd3,
      C_BRANCH = 4'd4,
      C_LOAD   = 4'd5,
      C_STORE  = 4'd6,
      C_OPIMM  = 4'd7,
      C_OP     = 4'd8,
      C_FENCE  = 4'd9
   } class_t;

   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_FENCE  = 7'b0001111;
   // Last wait count before the one that would exhaust the budget.
   localparam logic [15:0] TMO_LAST   = 16'(MEM_TIMEOUT - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   class_t                 r_class;
   logic [3:0]             r_alu_op;
   logic [15:0]            r_tmo_cnt;
   logic [CNT_WIDTH-1:0]   r_instret;

   class_t                 w_class;
   logic                   w_legal;
   logic [3:0]             w_alu_op;
   logic                   w_waiting;
   logic                   w_tmo_hit;
   logic                   w_sel_alu0;
   logic                   w_sel_alu1;
   logic                   w_sel_ex;
   logic                   w_unused_funct7;

   // Only funct7[5] matters (SUB/SRA/SRAI); the remaining bits are don't-care.
   assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

   // A memory wait is a FETCH/MEM cycle whose request is not completed.
   assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem.mem_ready;
   // Budget exhausted only when this cycle is also a wait: a late ready wins.
   assign w_tmo_hit = w_waiting && (r_tmo_cnt == TMO_LAST);

   assign instret     = r_instret;
   assign o_dbg_state = r_state;

   // Opcode classification and ALU operation derived from the instruction fields.
   always_comb begin
      w_class  = C_FENCE;
      w_legal  = 1'b1;
      w_alu_op = 4'b0000;
      case (opcode)
         OPC_LUI:    w_class = C_LUI;
         OPC_AUIPC:  w_class = C_AUIPC;
         OPC_JAL:    w_class = C_JAL;
         OPC_JALR:   w_class = C_JALR;
         OPC_BRANCH: w_class = C_BRANCH;
         OPC_LOAD:   w_class = C_LOAD;
         OPC_STORE:  w_class = C_STORE;
         OPC_OPIMM: begin
            w_class  = C_OPIMM;
            w_alu_op = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
         end
         OPC_OP: begin
            w_class  = C_OP;
            w_alu_op = {funct7[5], funct3};
         end
         OPC_FENCE:  w_class = C_FENCE;
         default:    w_legal = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH: begin
            if (mem.mem_ready)  w_next_state = S_DECODE;
            else if (w_tmo_hit) w_next_state = S_TRAP;
         end
         S_DECODE: w_next_state = w_legal ? S_EXEC : S_TRAP;
         S_EXEC:   w_next_state = ((r_class == C_LOAD) || (r_class == C_STORE)) ? S_MEM : S_WB;
         S_MEM: begin
            if (mem.mem_ready)  w_next_state = S_WB;
            else if (w_tmo_hit) w_next_state = S_TRAP;
         end
         S_WB:     w_next_state = S_FETCH;
         S_TRAP:   w_next_state = S_TRAP;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Class register: captured once in DECODE and held until the next DECODE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_class  <= C_LUI;
         r_alu_op <= 4'b0000;
      end else if (r_state == S_DECODE) begin
         r_class  <= w_class;
         r_alu_op <= w_alu_op;
      end
   end

   // Memory wait counter: runs during unanswered requests, zero otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_tmo_cnt <= 16'd0;
      else if (w_waiting) r_tmo_cnt <= r_tmo_cnt + 16'd1;
      else                r_tmo_cnt <= 16'd0;
   end

   // Retired-instruction counter: one per WB, wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)             r_instret <= '0;
      else if (r_state == S_WB) r_instret <= r_instret + CNT_WIDTH'(1);
   end

   // Operand selects implied by the latched instruction class.
   always_comb begin
      w_sel_alu0 = 1'b0;
      w_sel_alu1 = 1'b0;
      w_sel_ex   = 1'b0;
      case (r_class)
         C_LUI:                           w_sel_ex = 1'b1;
         C_AUIPC, C_JAL, C_BRANCH: begin
            w_sel_alu0 = 1'b1;
            w_sel_alu1 = 1'b1;
         end
         C_JALR, C_LOAD, C_STORE, C_OPIMM: w_sel_alu1 = 1'b1;
         default: ;
      endcase
   end

   // Datapath and memory controls from state and class register.
   always_comb begin
      mem.mem_req      = 1'b0;
      mem.mem_we       = 1'b0;
      mem.mem_addr_sel = 1'b0;
      ir_wr_en         = 1'b0;
      pc_wr_en         = 1'b0;
      rf_wr_en         = 1'b0;
      sel_alu0         = 1'b0;
      sel_alu1         = 1'b0;
      sel_ex           = 1'b0;
      sel_res          = 1'b0;
      sel_rf_wr        = 1'b0;
      sel_pc           = 1'b0;
      alu_op           = 4'b0000;
      trap             = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem.mem_req = 1'b1;
            ir_wr_en    = mem.mem_ready;
         end
         S_EXEC: begin
            sel_alu0 = w_sel_alu0;
            sel_alu1 = w_sel_alu1;
            sel_ex   = w_sel_ex;
            alu_op   = r_alu_op;
         end
         S_MEM: begin
            mem.mem_req      = 1'b1;
            mem.mem_addr_sel = 1'b1;
            mem.mem_we       = (r_class == C_STORE);
            sel_alu0         = w_sel_alu0;
            sel_alu1         = w_sel_alu1;
            sel_ex           = w_sel_ex;
            alu_op           = r_alu_op;
         end
         S_WB: begin
            sel_alu0  = w_sel_alu0;
            sel_alu1  = w_sel_alu1;
            sel_ex    = w_sel_ex;
            alu_op    = r_alu_op;
            pc_wr_en  = 1'b1;
            rf_wr_en  = !((r_class == C_BRANCH) || (r_class == C_STORE) || (r_class == C_FENCE));
            sel_res   = (r_class != C_LOAD);
            sel_rf_wr = (r_class == C_JAL) || (r_class == C_JALR);
            sel_pc    = (r_class == C_JAL) || (r_class == C_JALR) ||
                        ((r_class == C_BRANCH) && br_taken);
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed table, hand-written trap/reset sequences and
// random instruction streams checked cycle by cycle against a per-instruction
// timeline model.
module tb_mc_ctrl;

   localparam int TMO       = 20;
   localparam int CW        = 32;
   localparam int TRAP_HOLD = 100;
   localparam int N_RAND    = 200;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [6:0]    opcode = '0;
   logic [2:0]    funct3 = '0;
   logic [6:0]    funct7 = '0;
   logic          br_taken = 1'b0;
   logic          ir_wr_en, pc_wr_en, rf_wr_en, sel_alu0, sel_alu1, sel_ex;
   logic          sel_res, sel_rf_wr, sel_pc, trap;
   logic [3:0]    alu_op;
   logic [CW-1:0] instret;
   logic [2:0]    dbg_state;

   mc_ctrl_if mem_bus ();

   mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .br_taken    (br_taken),
      .mem         (mem_bus),
      .ir_wr_en    (ir_wr_en),
      .pc_wr_en    (pc_wr_en),
      .rf_wr_en    (rf_wr_en),
      .sel_alu0    (sel_alu0),
      .sel_alu1    (sel_alu1),
      .sel_ex      (sel_ex),
      .sel_res     (sel_res),
      .sel_rf_wr   (sel_rf_wr),
      .sel_pc      (sel_pc),
      .alu_op      (alu_op),
      .trap        (trap),
      .instret     (instret),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [16:0] exp_q[$];     // expected output vector per cycle
   logic [2:0]  stim_q[$];    // {is_wb, mem_ready, br_taken} per cycle
   logic [31:0] m_instret = '0;
   bit          after_reset = 1'b0;
   int          g_pre, g_exec_idx, g_wb_idx;
   logic [6:0]  g_exec;
   logic [3:0]  g_wb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Vector: {req,we,asel,ir,pcw,rfw,a0,a1,ex,res,rfwr,spc,alu_op[3:0],trap}
   function automatic logic [16:0] act_vec();
      return {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel, ir_wr_en, pc_wr_en,
              rf_wr_en, sel_alu0, sel_alu1, sel_ex, sel_res, sel_rf_wr, sel_pc, alu_op, trap};
   endfunction

   function automatic logic [16:0] mk(bit req, bit we, bit asel, bit ir, bit pcw, bit rfw,
                                      bit a0, bit a1, bit ex, bit res, bit rfwr, bit spc,
                                      logic [3:0] aop, bit trp);
      return {req, we, asel, ir, pcw, rfw, a0, a1, ex, res, rfwr, spc, aop, trp};
   endfunction

   task automatic push(input logic [16:0] e, input bit rdy, input bit bt, input bit wb);
      exp_q.push_back(e);
      stim_q.push_back({wb, rdy, bt});
   endtask

   task automatic push_trap();
      for (int k = 0; k < TRAP_HOLD; k++)
         push(mk(0,0,0,0,0,0,0,0,0,0,0,0,4'd0,1), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b0);
   endtask

   // Reference timeline for one instruction, built from the ISA-level rules:
   // fetch (with waits), decode, exec, optional memory phase, write-back.
   task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input bit bt, input int fw, input int mw, output bit trapped);
      bit         legal, is_mem, a0, a1, ex;
      logic [3:0] aop;
      trapped = 1'b0;
      if (after_reset) begin
         push('0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b0);
         after_reset = 1'b0;
      end
      for (int k = 0; k < fw && k < TMO; k++)
         push(mk(1,0,0,0,0,0,0,0,0,0,0,0,4'd0,0), 1'b0, 1'($urandom_range(0,1)), 1'b0);
      if (fw >= TMO) begin
         push_trap(); trapped = 1'b1; return;
      end
      push(mk(1,0,0,1,0,0,0,0,0,0,0,0,4'd0,0), 1'b1, 1'($urandom_range(0,1)), 1'b0);
      push('0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b0);
      legal = op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                         OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE};
      if (!legal) begin
         push_trap(); trapped = 1'b1; return;
      end
      is_mem = (op == OPC_LOAD) || (op == OPC_STORE);
      a0  = op inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH};
      a1  = op inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OPIMM};
      ex  = (op == OPC_LUI);
      aop = (op == OPC_OP)    ? {f7[5], f3} :
            (op == OPC_OPIMM) ? {(f3 == 3'd5) & f7[5], f3} : 4'd0;
      push(mk(0,0,0,0,0,0,a0,a1,ex,0,0,0,aop,0), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b0);
      if (is_mem) begin
         for (int k = 0; k < mw && k < TMO; k++)
            push(mk(1,op == OPC_STORE,1,0,0,0,a0,a1,ex,0,0,0,aop,0), 1'b0, 1'($urandom_range(0,1)), 1'b0);
         if (mw >= TMO) begin
            push_trap(); trapped = 1'b1; return;
         end
         push(mk(1,op == OPC_STORE,1,0,0,0,a0,a1,ex,0,0,0,aop,0), 1'b1, 1'($urandom_range(0,1)), 1'b0);
      end
      push(mk(0,0,0,0,1,
              !(op inside {OPC_BRANCH, OPC_STORE, OPC_FENCE}),
              a0, a1, ex,
              op != OPC_LOAD,
              op inside {OPC_JAL, OPC_JALR},
              (op inside {OPC_JAL, OPC_JALR}) || ((op == OPC_BRANCH) && bt),
              aop, 0),
           1'($urandom_range(0,1)), bt, 1'b1);
   endtask

   // Driver + comparator: one queued cycle per clock, inputs at the falling edge.
   task automatic run_queue(input int limit);
      int          idx = 0;
      logic [2:0]  s;
      logic [16:0] e, a;
      while (exp_q.size() > 0 && idx < limit) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(negedge clk);
         mem_bus.mem_ready = s[1];
         br_taken          = s[0];
         #1;
         a = act_vec();
         chk("cycle_outputs", {15'd0, a}, {15'd0, e});
         chk("instret", instret, m_instret);
         if (idx == g_exec_idx) g_exec = {a[10:8], a[4:1]};
         if (a[12] && g_wb_idx < 0) begin
            g_wb_idx = idx - g_pre + 1;
            g_wb     = {a[11], a[7:5]};
         end
         if (s[2]) m_instret++;
         idx++;
      end
      exp_q.delete();
      stim_q.delete();
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input bit bt, input int fw, input int mw, input int limit,
                            output bit trapped);
      opcode     = op;
      funct3     = f3;
      funct7     = f7;
      g_pre      = after_reset ? 1 : 0;
      g_exec_idx = g_pre + fw + 2;
      g_wb_idx   = -1;
      g_exec     = '0;
      g_wb       = '0;
      model_instr(op, f3, f7, bt, fw, mw, trapped);
      run_queue(limit);
   endtask

   task automatic reset_now();
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {15'd0, act_vec()}, 32'd0);
      chk("async_reset_instret", instret, 32'd0);
   endtask

   task automatic finish_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {15'd0, act_vec()}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      chk("reset_state", {29'd0, dbg_state}, 32'd0);
      reset_n     = 1'b1;
      m_instret   = '0;
      after_reset = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         bt;
      int         fw;
      int         mw;
      int         cyc;     // FETCH..WB inclusive
      logic [6:0] ex_sel;  // {alu0, alu1, ex, alu_op}
      logic [3:0] wb_sel;  // {rf_wr_en, sel_res, sel_rf_wr, sel_pc}
   } vec_t;

   vec_t tbl[17];

   initial begin
      bit          tr;
      logic [6:0]  rop;
      int          r;

      tbl[0]  = '{OPC_OPIMM,  3'b000, 7'h00, 1'b0, 0,     0,     4,  7'b010_0000, 4'b1100}; // ADDI x1,x0,5
      tbl[1]  = '{OPC_LOAD,   3'b010, 7'h00, 1'b0, 0,     3,     8,  7'b010_0000, 4'b1000}; // LW, 3 waits
      tbl[2]  = '{OPC_BRANCH, 3'b000, 7'h00, 1'b1, 0,     0,     4,  7'b110_0000, 4'b0101}; // BEQ taken
      tbl[3]  = '{OPC_BRANCH, 3'b001, 7'h20, 1'b0, 0,     0,     4,  7'b110_0000, 4'b0100}; // BNE not taken
      tbl[4]  = '{OPC_JAL,    3'b000, 7'h00, 1'b0, 0,     0,     4,  7'b110_0000, 4'b1111}; // JAL
      tbl[5]  = '{OPC_STORE,  3'b010, 7'h00, 1'b0, 0,     0,     5,  7'b010_0000, 4'b0100}; // SW
      tbl[6]  = '{OPC_OP,     3'b000, 7'h20, 1'b0, 0,     0,     4,  7'b000_1000, 4'b1100}; // SUB
      tbl[7]  = '{OPC_OPIMM,  3'b101, 7'h20, 1'b0, 0,     0,     4,  7'b010_1101, 4'b1100}; // SRAI
      tbl[8]  = '{OPC_OPIMM,  3'b001, 7'h20, 1'b0, 0,     0,     4,  7'b010_0001, 4'b1100}; // SLLI
      tbl[9]  = '{OPC_LUI,    3'b000, 7'h00, 1'b0, 0,     0,     4,  7'b001_0000, 4'b1100}; // LUI
      tbl[10] = '{OPC_AUIPC,  3'b000, 7'h00, 1'b0, 0,     0,     4,  7'b110_0000, 4'b1100}; // AUIPC
      tbl[11] = '{OPC_JALR,   3'b000, 7'h00, 1'b1, 0,     0,     4,  7'b010_0000, 4'b1111}; // JALR
      tbl[12] = '{OPC_FENCE,  3'b000, 7'h00, 1'b1, 0,     0,     4,  7'b000_0000, 4'b0100}; // FENCE
      tbl[13] = '{OPC_OP,     3'b000, 7'h00, 1'b0, 2,     0,     6,  7'b000_0000, 4'b1100}; // ADD, 2 fetch waits
      tbl[14] = '{OPC_OP,     3'b000, 7'h00, 1'b0, TMO-1, 0,     23, 7'b000_0000, 4'b1100}; // ready on last fetch cycle
      tbl[15] = '{OPC_LOAD,   3'b000, 7'h00, 1'b0, 0,     TMO-1, 24, 7'b010_0000, 4'b1000}; // ready on last mem cycle
      tbl[16] = '{OPC_OP,     3'b101, 7'h20, 1'b0, 0,     0,     4,  7'b000_1101, 4'b1100}; // SRA

      mem_bus.mem_ready = 1'b0;
      finish_reset();

      for (int i = 0; i < 17; i++) begin
         run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].bt, tbl[i].fw, tbl[i].mw, 1 << 30, tr);
         chk("tbl_cycles",   32'(g_wb_idx), 32'(tbl[i].cyc));
         chk("tbl_exec_sel", {25'd0, g_exec}, {25'd0, tbl[i].ex_sel});
         chk("tbl_wb_sel",   {28'd0, g_wb},   {28'd0, tbl[i].wb_sel});
         @(posedge clk);
         #1;
         chk("tbl_instret", instret, 32'(i + 1));
      end

      // Illegal opcode traps and stays trapped.
      run_instr(7'h7F, 3'd0, 7'd0, 1'b0, 0, 0, 1 << 30, tr);
      chk("trap_illegal", {31'd0, trap}, 32'd1);
      chk("trap_illegal_state", {29'd0, dbg_state}, 32'd6);
      reset_now();
      finish_reset();

      // Fetch never answered.
      run_instr(OPC_OP, 3'd0, 7'd0, 1'b0, TMO, 0, 1 << 30, tr);
      chk("trap_fetch_timeout", {31'd0, trap}, 32'd1);
      reset_now();
      finish_reset();

      // Load never answered.
      run_instr(OPC_LOAD, 3'd2, 7'd0, 1'b0, 0, TMO, 1 << 30, tr);
      chk("trap_mem_timeout", {31'd0, trap}, 32'd1);
      reset_now();
      finish_reset();

      // Reset while a load is waiting in MEM, then restart cleanly.
      run_instr(OPC_OPIMM, 3'd0, 7'd0, 1'b0, 0, 0, 1 << 30, tr);
      run_instr(OPC_LOAD, 3'd2, 7'd0, 1'b0, 0, 5, 5, tr);
      chk("mid_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
      chk("mid_mem_instret", instret, 32'd1);
      reset_now();
      finish_reset();
      run_instr(OPC_OPIMM, 3'd0, 7'd0, 1'b0, 0, 0, 1 << 30, tr);
      chk("restart_cycles", 32'(g_wb_idx), 32'd4);

      // Random instruction stream.
      for (int n = 0; n < N_RAND; n++) begin
         int fw, mw;
         r = $urandom_range(0, 99);
         if (r < 4) begin
            rop = 7'($urandom_range(0, 127));
            while (rop inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                               OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE})
               rop = 7'($urandom_range(0, 127));
         end else begin
            case ($urandom_range(0, 9))
               0: rop = OPC_LUI;    1: rop = OPC_AUIPC; 2: rop = OPC_JAL;
               3: rop = OPC_JALR;   4: rop = OPC_BRANCH; 5: rop = OPC_LOAD;
               6: rop = OPC_STORE;  7: rop = OPC_OPIMM;  8: rop = OPC_OP;
               default: rop = OPC_FENCE;
            endcase
         end
         r  = $urandom_range(0, 99);
         fw = (r < 2) ? TMO : (r < 5) ? TMO - 1 : $urandom_range(0, 3);
         r  = $urandom_range(0, 99);
         mw = (r < 3) ? TMO : (r < 6) ? TMO - 1 : $urandom_range(0, 3);
         run_instr(rop, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                   1'($urandom_range(0, 1)), fw, mw, 1 << 30, tr);
         if (tr) begin
            chk("rand_trap", {31'd0, trap}, 32'd1);
            reset_now();
            finish_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
